// File: rtl/baud_gen_frac.sv
// baud_gen_frac: runtime-programmable UART baud tick generator.
// One phase counter yields an oversample tick (tick_rx) and a bit tick
// (tick_tx) on every OVERSAMPLE-th tick_rx. Divisor writes are held in a
// shadow register and only take effect at a period start. resync and a
// rising en restart the phase.
// Optional feature macro: BAUD_GEN_FRAC_EN enables the fractional
// accumulator. Without it every period is exactly div_int cycles and the
// fractional inputs and parameters are ignored.
module baud_gen_frac #(
  parameter int                DIV_W        = 16,
  parameter int                FRAC_W       = 8,
  parameter int                OVERSAMPLE   = 16,
  parameter logic [DIV_W-1:0]  RST_DIV_INT  = DIV_W'(32'd27),
  parameter logic [FRAC_W-1:0] RST_DIV_FRAC = FRAC_W'(32'd32)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          resync,
  input  logic                          cfg_we,
  input  logic [DIV_W-1:0]              cfg_div_int,
  input  logic [FRAC_W-1:0]             cfg_div_frac,
  output logic                          cfg_busy,
  output logic                          tick_rx,
  output logic                          tick_tx,
  output logic [$clog2(OVERSAMPLE)-1:0] sub_phase
);

  localparam int SUB_W = $clog2(OVERSAMPLE);

  // Registered state
  logic              en_prev_q, en_prev_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic              tick_rx_q, tick_rx_d;
  logic              tick_tx_q, tick_tx_d;
  logic              busy_q, busy_d;
  logic [DIV_W-1:0]  div_int_q, div_int_d;
  logic [DIV_W-1:0]  sh_int_q, sh_int_d;
`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic [FRAC_W-1:0] sel_frac_s;
  logic [FRAC_W-1:0] acc_base_s;
  logic [FRAC_W:0]   acc_sum_s;
`else
  logic              unused_frac_s;
`endif

  // Combinational helpers
  logic              restart_s;
  logic              start_s;
  logic [DIV_W-1:0]  sel_int_s;
  logic [DIV_W-1:0]  int_eff_s;
  logic              carry_s;

  // Event decode, divisor selection for this period start and the carry
  always_comb begin
    restart_s = en & (resync | ~en_prev_q);
    start_s   = restart_s | (en & tick_rx_q);

    // A write coinciding with a restart is used directly; otherwise a
    // pending shadow wins over the active divisor.
    if (restart_s && cfg_we) begin
      sel_int_s = cfg_div_int;
    end else if (busy_q) begin
      sel_int_s = sh_int_q;
    end else begin
      sel_int_s = div_int_q;
    end

    if (sel_int_s < DIV_W'(32'd2)) begin
      int_eff_s = DIV_W'(32'd2);
    end else begin
      int_eff_s = sel_int_s;
    end

`ifdef BAUD_GEN_FRAC_EN
    if (restart_s && cfg_we) begin
      sel_frac_s = cfg_div_frac;
    end else if (busy_q) begin
      sel_frac_s = sh_frac_q;
    end else begin
      sel_frac_s = div_frac_q;
    end

    // A restart begins the accumulation afresh from zero.
    if (restart_s) begin
      acc_base_s = '0;
    end else begin
      acc_base_s = acc_q;
    end

    acc_sum_s = {1'b0, acc_base_s} + {1'b0, sel_frac_s};
    carry_s   = acc_sum_s[FRAC_W];
`else
    carry_s   = 1'b0;
`endif
  end

`ifndef BAUD_GEN_FRAC_EN
  assign unused_frac_s = ^{cfg_div_frac, RST_DIV_FRAC};
`endif

  // Next-state logic for the period counter, ticks, sub-phase and config
  always_comb begin
    en_prev_d  = en_prev_q;
    cnt_d      = cnt_q;
    sub_d      = sub_q;
    tick_rx_d  = 1'b0;
    tick_tx_d  = 1'b0;
    busy_d     = busy_q;
    div_int_d  = div_int_q;
    sh_int_d   = sh_int_q;
`ifdef BAUD_GEN_FRAC_EN
    acc_d      = acc_q;
    div_frac_d = div_frac_q;
    sh_frac_d  = sh_frac_q;
`endif

    if (!en) begin
      // Idle: phase held at zero, any pending divisor is applied at once.
      en_prev_d = 1'b0;
      cnt_d     = '0;
      sub_d     = '0;
`ifdef BAUD_GEN_FRAC_EN
      acc_d     = '0;
`endif
      if (busy_q) begin
        div_int_d  = sh_int_q;
`ifdef BAUD_GEN_FRAC_EN
        div_frac_d = sh_frac_q;
`endif
      end else begin
        div_int_d  = div_int_q;
      end
      if (cfg_we) begin
        sh_int_d  = cfg_div_int;
`ifdef BAUD_GEN_FRAC_EN
        sh_frac_d = cfg_div_frac;
`endif
        busy_d    = 1'b1;
      end else begin
        busy_d    = 1'b0;
      end
    end else begin
      en_prev_d = 1'b1;

      // A restart suppresses the natural tick that would otherwise fire.
      tick_rx_d = ~restart_s & (cnt_q == DIV_W'(32'd1));
      tick_tx_d = tick_rx_d & (sub_q == SUB_W'(OVERSAMPLE - 1));

      if (restart_s) begin
        sub_d = '0;
      end else if (tick_rx_d) begin
        sub_d = sub_q + SUB_W'(32'd1);
      end else begin
        sub_d = sub_q;
      end

      if (start_s) begin
        // Load remaining cycles of the new period; tick fires when it hits 1.
        cnt_d      = int_eff_s - DIV_W'(32'd1) + {{(DIV_W-1){1'b0}}, carry_s};
        div_int_d  = sel_int_s;
`ifdef BAUD_GEN_FRAC_EN
        acc_d      = acc_sum_s[FRAC_W-1:0];
        div_frac_d = sel_frac_s;
`endif
        // A write on a tick cycle waits for the following period start.
        if (cfg_we && !restart_s) begin
          sh_int_d  = cfg_div_int;
`ifdef BAUD_GEN_FRAC_EN
          sh_frac_d = cfg_div_frac;
`endif
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(32'd1);
        end else begin
          cnt_d = '0;
        end
        if (cfg_we) begin
          sh_int_d  = cfg_div_int;
`ifdef BAUD_GEN_FRAC_EN
          sh_frac_d = cfg_div_frac;
`endif
          busy_d    = 1'b1;
        end else begin
          busy_d    = busy_q;
        end
      end
    end
  end

  // State registers with asynchronous reset to the power-on divisor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_prev_q  <= 1'b0;
      cnt_q      <= '0;
      sub_q      <= '0;
      tick_rx_q  <= 1'b0;
      tick_tx_q  <= 1'b0;
      busy_q     <= 1'b0;
      div_int_q  <= RST_DIV_INT;
      sh_int_q   <= RST_DIV_INT;
`ifdef BAUD_GEN_FRAC_EN
      acc_q      <= '0;
      div_frac_q <= RST_DIV_FRAC;
      sh_frac_q  <= RST_DIV_FRAC;
`endif
    end else begin
      en_prev_q  <= en_prev_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      tick_rx_q  <= tick_rx_d;
      tick_tx_q  <= tick_tx_d;
      busy_q     <= busy_d;
      div_int_q  <= div_int_d;
      sh_int_q   <= sh_int_d;
`ifdef BAUD_GEN_FRAC_EN
      acc_q      <= acc_d;
      div_frac_q <= div_frac_d;
      sh_frac_q  <= sh_frac_d;
`endif
    end
  end

  assign cfg_busy  = busy_q;
  assign tick_rx   = tick_rx_q;
  assign tick_tx   = tick_tx_q;
  assign sub_phase = sub_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Testbench for baud_gen_frac (default parameters). The reference model
// tracks absolute tick deadlines, a pending-divisor flag and the fraction
// accumulated as an integer; it predicts every output cycle by cycle.
// Follows BAUD_GEN_FRAC_EN the same way the design does.
module tb_baud_gen_frac;

`ifdef BAUD_GEN_FRAC_EN
  localparam int FRAC_ON = 1;
`else
  localparam int FRAC_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        resync;
  logic        cfg_we;
  logic [15:0] cfg_div_int;
  logic [7:0]  cfg_div_frac;
  logic        cfg_busy;
  logic        tick_rx;
  logic        tick_tx;
  logic [3:0]  sub_phase;

  baud_gen_frac dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .resync       (resync),
    .cfg_we       (cfg_we),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_busy     (cfg_busy),
    .tick_rx      (tick_rx),
    .tick_tx      (tick_tx),
    .sub_phase    (sub_phase)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc   = 0;
  bit     got_tick;
  longint tick_cyc;

  // Reference model state
  int     m_int, m_frac, m_sh_int, m_sh_frac, m_acc, m_sub;
  bit     m_pend, m_en_prev;
  longint m_tick_at;
  bit     e_rx, e_tx, e_busy;
  int     e_sub;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_int = 27; m_frac = 32; m_sh_int = 27; m_sh_frac = 32;
    m_acc = 0; m_sub = 0; m_pend = 0; m_en_prev = 0; m_tick_at = -1;
    e_rx = 0; e_tx = 0; e_busy = 0; e_sub = 0;
  endtask

  // Predict outputs of the next cycle from the inputs of this one.
  task automatic model_step();
    bit restart, start, nt;
    int ui, uf, s, carry, p;
    if (!en) begin
      m_tick_at = -1; m_acc = 0; m_sub = 0; e_rx = 0; e_tx = 0;
      if (m_pend) begin m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0; end
      if (cfg_we) begin m_sh_int = cfg_div_int; m_sh_frac = cfg_div_frac; m_pend = 1; end
      m_en_prev = 0;
    end else begin
      restart = resync || !m_en_prev;
      start   = restart || e_rx;
      nt      = (m_tick_at == cyc + 1) && !restart;
      if (start) begin
        if (restart && cfg_we) begin ui = cfg_div_int; uf = cfg_div_frac; m_pend = 0; end
        else if (m_pend) begin ui = m_sh_int; uf = m_sh_frac; m_pend = 0; end
        else begin ui = m_int; uf = m_frac; end
        m_int = ui; m_frac = uf;
        s = (restart ? 0 : m_acc) + uf;
        carry = (FRAC_ON != 0 && s >= 256) ? 1 : 0;
        m_acc = s % 256;
        p = ((ui < 2) ? 2 : ui) + carry;
        m_tick_at = cyc + p;
        if (cfg_we && !restart) begin m_sh_int = cfg_div_int; m_sh_frac = cfg_div_frac; m_pend = 1; end
      end else if (cfg_we) begin
        m_sh_int = cfg_div_int; m_sh_frac = cfg_div_frac; m_pend = 1;
      end
      if (restart) m_sub = 0;
      e_rx = nt;
      e_tx = nt && (m_sub == 15);
      if (nt) m_sub = (m_sub + 1) % 16;
      m_en_prev = 1;
    end
    e_sub  = m_sub;
    e_busy = m_pend;
  endtask

  // Compare this cycle's outputs, advance the model, move to next negedge.
  task automatic cycle();
    check("tick_rx",   tick_rx,   e_rx);
    check("tick_tx",   tick_tx,   e_tx);
    check("sub_phase", sub_phase, e_sub);
    check("cfg_busy",  cfg_busy,  e_busy);
    got_tick = tick_rx;
    if (tick_rx) tick_cyc = cyc;
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_tick(input int limit, output longint t);
    bit seen = 0;
    t = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      cycle();
      if (got_tick) begin seen = 1; t = tick_cyc; end
    end
    check("tick_seen", seen, 1);
  endtask

  task automatic write_cfg(input int di, input int df);
    cfg_we = 1; cfg_div_int = 16'(di); cfg_div_frac = 8'(df);
    cycle();
    cfg_we = 0;
  endtask

  initial begin
    longint t[17];
    longint r, a, b, c, s, e;
    int cnt;

    rst = 1; en = 1; resync = 0; cfg_we = 0;
    cfg_div_int = 16'd0; cfg_div_frac = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;

    // Defaults after reset: gap pattern and 16-tick span
    r = cyc;
    for (int k = 0; k < 17; k++) wait_tick(60, t[k]);
    check("first_gap", t[0] - r, 27);
    for (int k = 1; k <= 8; k++)
      check("default_gap", t[k] - t[k-1], (FRAC_ON != 0 && (k + 1) % 8 == 0) ? 28 : 27);
    check("span16", t[16] - t[0], (FRAC_ON != 0) ? 434 : 432);

    // Mid-period divisor write
    repeat (3) cycle();
    write_cfg(10, 0);
    wait_tick(60, a);
    wait_tick(60, b);
    wait_tick(60, c);
    check("cfg_gap1", b - a, 10);
    check("cfg_gap2", c - b, 10);

    // Resync five cycles after a tick
    while (cyc < c + 5) cycle();
    resync = 1; s = cyc;
    cycle();
    resync = 0;
    check("resync_sub", sub_phase, 0);
    wait_tick(60, a);
    check("resync_gap", a - s, 10);

    // Clamped divisor, enable gap
    write_cfg(1, 0);
    wait_tick(60, a);
    wait_tick(60, b);
    wait_tick(60, c);
    check("clamp_gap1", b - a, 2);
    check("clamp_gap2", c - b, 2);
    en = 0;
    cycle();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (got_tick) cnt++;
    end
    check("idle_ticks", cnt, 0);
    en = 1; e = cyc;
    wait_tick(10, a);
    check("en_rise_gap", a - e, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      resync = ($urandom_range(63) == 0);
      cfg_we = ($urandom_range(39) == 0);
      cfg_div_int  = 16'($urandom_range(12));
      cfg_div_frac = 8'($urandom_range(255));
      if (en) en = ($urandom_range(299) != 0);
      else    en = ($urandom_range(3) == 0);
      cycle();
    end
    resync = 0; cfg_we = 0; en = 1;
    repeat (4) cycle();

    // Reset mid-period while a write is pending
    wait_tick(60, a);
    repeat (2) cycle();
    write_cfg(5, 7);
    check("busy_before_rst", cfg_busy, 1);
    #2 rst = 1;
    #1;
    check("rst_tick_rx",   tick_rx,   0);
    check("rst_tick_tx",   tick_tx,   0);
    check("rst_cfg_busy",  cfg_busy,  0);
    check("rst_sub_phase", sub_phase, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    r = cyc;
    wait_tick(60, a);
    check("post_rst_gap", a - r, 27);
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
